// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer for the 5-stage RV32I pipeline.
// It does three jobs:
// - Detects an enabled pending interrupt, or an mret, on the instruction in EX.
// - Kills younger instructions and lets older ones drain.
// - Strobes mepc/mcause/mstatus and redirects the PC to the trap vector or to mepc.
module trap_sequencer #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic            mie_meie,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            ex_valid,
  input  logic            mret_ex,
  input  logic [XLEN-1:0] pc_ex,
  output logic            stall_fetch,
  output logic            flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_wdata,
  output logic            mstatus_we,
  output logic            mie_wdata,
  output logic            mpie_wdata,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SAVE     = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_MRET     = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  // External interrupt outranks the timer; codes follow the privileged spec.
  function automatic logic [4:0] irq_code(input logic ext_pending);
    return ext_pending ? 5'd11 : 5'd7;
  endfunction

  // Interrupt mcause: interrupt bit set, exception code in the low bits.
  function automatic logic [XLEN-1:0] mcause_of(input logic [4:0] code);
    return {1'b1, {(XLEN-6){1'b0}}, code};
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [2:0]      cnt_r;
  logic [XLEN-1:0] epc_r;
  logic [4:0]      cause_r;
  logic            mie_r;

  logic            pend_ext_s;
  logic            pend_tmr_s;
  logic            take_irq_s;
  logic            take_mret_s;
  logic [XLEN-1:0] vec_base_s;
  logic [XLEN-1:0] vec_off_s;

  // Detection terms. Detection is gated by rst_n so that every output reads 0 while reset is held.
  always_comb begin
    pend_ext_s  = irq_ext & mie_meie;
    pend_tmr_s  = irq_timer & mie_mtie;
    take_irq_s  = rst_n & (state_r == ST_IDLE) & ex_valid & mstatus_mie
                  & (pend_ext_s | pend_tmr_s) & ~mret_ex;
    take_mret_s = rst_n & (state_r == ST_IDLE) & ex_valid & mret_ex;
    vec_base_s  = {mtvec[XLEN-1:2], 2'b00};
    vec_off_s   = {{(XLEN-7){1'b0}}, cause_r, 2'b00};
  end

  // State register plus the trap context latched at detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      epc_r   <= {XLEN{1'b0}};
      cause_r <= 5'd0;
      mie_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (take_irq_s) begin
        cnt_r   <= DRAIN_LOAD;
        epc_r   <= pc_ex;
        cause_r <= irq_code(pend_ext_s);
        mie_r   <= mstatus_mie;
      end else if (state_r == ST_DRAIN && cnt_r != 3'd0) begin
        cnt_r <= cnt_r - 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state and output decode. The IDLE outputs are Mealy so that the EX instruction dies in the detect cycle.
  always_comb begin
    state_nxt_s  = state_r;
    stall_fetch  = 1'b0;
    flush        = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = {XLEN{1'b0}};
    mepc_we      = 1'b0;
    mepc_wdata   = {XLEN{1'b0}};
    mcause_we    = 1'b0;
    mcause_wdata = {XLEN{1'b0}};
    mstatus_we   = 1'b0;
    mie_wdata    = 1'b0;
    mpie_wdata   = 1'b0;
    busy         = 1'b1;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (take_mret_s) begin
          flush       = 1'b1;
          stall_fetch = 1'b1;
          state_nxt_s = ST_MRET;
        end else if (take_irq_s) begin
          flush       = 1'b1;
          stall_fetch = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        flush       = 1'b1;
        stall_fetch = 1'b1;
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_SAVE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_SAVE: begin
        flush        = 1'b1;
        stall_fetch  = 1'b1;
        mepc_we      = 1'b1;
        mepc_wdata   = epc_r;
        mcause_we    = 1'b1;
        mcause_wdata = mcause_of(cause_r);
        mstatus_we   = 1'b1;
        mie_wdata    = 1'b0;
        mpie_wdata   = mie_r;
        state_nxt_s  = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        // Vectored mode only applies to mtvec[1:0]==01; the reserved encodings fall back to direct.
        if (mtvec[1:0] == 2'b01) begin
          pc_target = vec_base_s + vec_off_s;
        end else begin
          pc_target = vec_base_s;
        end
        state_nxt_s = ST_IDLE;
      end
      ST_MRET: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = {mepc_in[XLEN-1:2], 2'b00};
        mstatus_we  = 1'b1;
        mie_wdata   = mstatus_mpie;
        mpie_wdata  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences machine-mode trap entry and `mret` return for the 5-stage RV32I pipeline with CSR support.
- Detects enabled pending interrupts or an `mret` in execute, then kills younger instructions and drains older ones.
- Drives the CSR file write strobes (`mepc`, `mcause`, `mstatus`) and redirects the PC to the trap vector or to `mepc`.
- Sits between the main decoder / CSR file and the hazard / PC-select logic.

Parameters:
- XLEN, 32, datapath and CSR width.
- DRAIN_CYCLES, 2, cycles to let instructions older than the trapped one (in MEM/WB) retire before CSR update; legal range 1..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_ext  in  1  external interrupt request, level
- irq_timer  in  1  timer interrupt request, level
- mstatus_mie  in  1  current `mstatus.MIE`
- mstatus_mpie  in  1  current `mstatus.MPIE`
- mie_meie  in  1  `mie.MEIE` enable
- mie_mtie  in  1  `mie.MTIE` enable
- mtvec  in  XLEN  current `mtvec` CSR
- mepc_in  in  XLEN  current `mepc` CSR
- ex_valid  in  1  execute stage holds a real, non-bubble instruction
- mret_ex  in  1  `mret` decoded for the instruction in execute
- pc_ex  in  XLEN  PC of the instruction in execute
- stall_fetch  out  1  freeze PC and IF/ID
- flush  out  1  kill IF/ID, ID/EX and the EX result (no EX/MEM register or memory write)
- pc_redirect  out  1  select pc_target as next PC
- pc_target  out  XLEN  redirect address
- mepc_we  out  1  `mepc` write strobe
- mepc_wdata  out  XLEN  `mepc` write data
- mcause_we  out  1  `mcause` write strobe
- mcause_wdata  out  XLEN  `mcause` write data
- mstatus_we  out  1  `mstatus` MIE/MPIE write strobe
- mie_wdata  out  1  new `MIE` value
- mpie_wdata  out  1  new `MPIE` value
- busy  out  1  sequencer not in IDLE

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE; epc_q=0, cause_q=0, mie_q=0.
  - All outputs 0, including pc_target and the wdata outputs.
- States: IDLE, DRAIN, SAVE, REDIRECT, MRET.
- Definitions:
  - pend_ext = irq_ext & mie_meie; pend_tmr = irq_timer & mie_mtie.
  - take_irq = IDLE & ex_valid & mstatus_mie & (pend_ext | pend_tmr) & !mret_ex.
  - take_mret = IDLE & ex_valid & mret_ex.
  - `mret` has priority over an interrupt in the same cycle. The interrupt is retaken after return if still pending.
- Priority and cause:
  - ext beats timer.
  - cause code 11 (ext) or 7 (timer).
  - mcause = {1'b1, zeros, code[4:0]}.
- Detect cycle T (IDLE, Mealy): on take_irq or take_mret, flush=1 and stall_fetch=1 combinationally, killing the instruction in EX.
- take_irq at T:
  - latch epc_q=pc_ex, cause_q, mie_q=mstatus_mie.
  - Counter loads DRAIN_CYCLES-1; go to DRAIN.
- DRAIN: stall_fetch=1, flush=1. Count down; at 0 go to SAVE.
- SAVE (1 cycle):
  - stall_fetch=1, flush=1.
  - mepc_we=1, mepc_wdata=epc_q.
  - mcause_we=1, mcause_wdata=cause.
  - mstatus_we=1, mie_wdata=0, mpie_wdata=mie_q.
  - Go to REDIRECT.
- REDIRECT (1 cycle):
  - pc_redirect=1, flush=1.
  - pc_target = {mtvec[XLEN-1:2],2'b00} if mtvec[1:0]==00 (direct).
  - pc_target = base + 4*code if mtvec[1:0]==01 (vectored).
  - Go to IDLE.
- take_mret at T: go to MRET.
- MRET (1 cycle):
  - mstatus_we=1, mie_wdata=mstatus_mpie, mpie_wdata=1.
  - pc_redirect=1, pc_target={mepc_in[XLEN-1:2],2'b00}, flush=1.
  - Go to IDLE.
- Latency:
  - Interrupt detect to redirect = DRAIN_CYCLES+2 cycles.
  - `mret` detect to redirect = 1 cycle.
  - busy=1 in every non-IDLE state.
- Boundaries:
  - Request sources ignored outside IDLE; levels stay pending.
  - Interrupt deasserting after T does not abort; the latched cause is used.
  - No detection when ex_valid=0 (bubble), so no bubble PC is ever saved as mepc.
  - Reset mid-sequence returns to IDLE immediately with no partial CSR write after reset.
  - All outputs outside the listed assertions are 0 (wdata outputs 0 when the strobe is low).

Test Plan:
- Timer IRQ, direct mode:
  - Stimulus: DRAIN_CYCLES=2, mie=1, mtie=1, irq_timer=1, pc_ex=0x40, mtvec=0x100.
  - Required: flush at T..T+3; at T+3 mepc=0x40, mcause=0x80000007, MIE=0, MPIE=1; at T+4 pc_redirect, pc_target=0x100.
- Ext+timer simultaneous, vectored:
  - Stimulus: mtvec=0x201.
  - Required: mcause=0x8000000B, pc_target=0x22C.
- `mret`:
  - Stimulus: mret_ex=1, ex_valid=1, mepc_in=0x44, mstatus_mpie=1.
  - Required: T flush; T+1 pc_redirect, pc_target=0x44, mie_wdata=1, mpie_wdata=1, mstatus_we.
- Masking:
  - Stimulus: irq_timer=1 with mstatus_mie=0, or with mie_mtie=0, or with ex_valid=0.
  - Required: no flush, busy=0, no CSR strobes for 10 cycles.
- `mret` and interrupt in the same cycle:
  - Stimulus: mret_ex=1 and irq_ext=1, MIE=1.
  - Required: MRET sequence first; the interrupt is taken on a later IDLE cycle.
- Reset mid-sequence:
  - Stimulus: deassert `rst_n` during DRAIN; irq_timer deasserted.
  - Required: all outputs 0 immediately, busy=0, no SAVE strobes after release.
